ma_decimator: RTL

//  Downstream stage of the moving-average filter. Consumes the filter result stream,

---
 rtl/ma_decimator_if.sv | 12 +
 rtl/ma_decimator.sv | 114 +++++++++++
 2 files changed

// File: rtl/ma_decimator_if.sv
// Output stream of the decimator: the FIFO head and its valid/ready handshake.
// A word transfers on a rising edge where valid=1 and ready=1; while valid=1 and ready=0, data and valid hold.
interface ma_decimator_if #(
  parameter int G_D_W = 10
);
  logic [G_D_W-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ma_decimator.sv
// Drops the filter warm-up samples, keeps one strobed result in every G_DEC,
// and buffers kept results in a first-word-fall-through FIFO with a sticky overflow flag.
module ma_decimator #(
  parameter int G_D_W     = 10,
  parameter int G_DEC     = 4,
  parameter int G_WARMUP  = 19,
  parameter int G_FIFO_AW = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ce,
  input  logic [G_D_W-1:0]     i_data,
  input  logic                 i_clr,
  ma_decimator_if.master       out_if,
  output logic [G_FIFO_AW:0]   o_level,
  output logic                 o_warm,
  output logic                 o_overflow,
  output logic                 o_dbg_state
);

  localparam int WCNT_W = (G_WARMUP > 1) ? $clog2(G_WARMUP) : 1;
  localparam int DCNT_W = (G_DEC > 1) ? $clog2(G_DEC) : 1;
  localparam int DEPTH  = 1 << G_FIFO_AW;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'((G_WARMUP > 0) ? G_WARMUP - 1 : 0);
  localparam logic [DCNT_W-1:0] DLAST = DCNT_W'(G_DEC - 1);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  localparam state_t START_STATE = (G_WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t                state;
  logic [WCNT_W-1:0]     wcnt;
  logic [DCNT_W-1:0]     dcnt;
  logic [G_FIFO_AW-1:0]  wr_ptr;
  logic [G_FIFO_AW-1:0]  rd_ptr;
  logic [G_FIFO_AW:0]    level_q;
  logic                  ovf_q;
  logic [G_D_W-1:0]      mem [DEPTH];

  logic keep;
  logic full;
  logic pop;
  logic push_ok;

  always_comb begin
    keep    = i_ce && (state == ST_RUN) && (dcnt == '0);
    full    = (level_q == (G_FIFO_AW+1)'(DEPTH));
    pop     = out_if.valid && out_if.ready;
    push_ok = keep && (!full || pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= START_STATE;
      wcnt    <= '0;
      dcnt    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (i_clr) begin
      state   <= START_STATE;
      wcnt    <= '0;
      dcnt    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (i_ce) begin
        case (state)
          ST_WARMUP: begin
            // The strobe that completes warm-up is itself still discarded.
            if (wcnt == WLAST) begin
              state <= ST_RUN;
              wcnt  <= '0;
              dcnt  <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          ST_RUN: begin
            dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
          end
          default: state <= ST_WARMUP;
        endcase
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (keep && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is forced to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push_ok && !i_clr) mem[wr_ptr] <= i_data;
  end

  assign out_if.valid = (level_q != '0);
  assign out_if.data  = out_if.valid ? mem[rd_ptr] : '0;
  assign o_level      = level_q;
  assign o_warm       = (state == ST_RUN);
  assign o_overflow   = ovf_q;
  assign o_dbg_state  = state;

endmodule
